// File: rtl/ofs_fim_if_pkg.sv
// Shared port interface package: port CSR bit positions, soft-reset
// FSM states and AFU status CSR count.
package ofs_fim_if_pkg;

    localparam int NUM_PORT_AFU_STATUS_CSRS = 2;

    localparam int PORT_CTRL_RST_BIT      = 0;
    localparam int PORT_CTRL_ACK_BIT      = 4;
    localparam int PORT_STS_TIMEOUT_BIT   = 1;
    localparam int PORT_STS_UNDERFLOW_BIT = 2;
    localparam int PORT_STS_OUTST_LSB     = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        RESET = 2'd2,
        ACK   = 2'd3
    } port_ctrl_state_e;

    function automatic logic [63:0] ctrl_readback(
        input logic [63:0] ctrl,
        input logic        ack
    );
        logic [63:0] v;
        v = ctrl;
        v[PORT_CTRL_ACK_BIT] = ack;
        return v;
    endfunction

endpackage

// File: rtl/port_csr_io_if.sv
// Port CSR I/O bundle: cr2out_* from the register block, inp2cr_*
// register-value inputs back to it.
interface port_csr_io_if;
    import ofs_fim_if_pkg::*;

    logic [63:0] cr2out_port_control;
    logic [63:0] cr2out_port_error;
    logic        cr2out_port_error_clear;
    logic [63:0] cr2out_port_error_mask;

    logic [63:0] inp2cr_port_control;
    logic [63:0] inp2cr_port_status;
    logic [63:0] inp2cr_port_error;
    logic [63:0] inp2cr_port_malformed_req_0;
    logic [63:0] inp2cr_port_malformed_req_1;
    logic [63:0] inp2cr_port_debug0;
    logic [63:0] inp2cr_port_stp_status;
    logic [NUM_PORT_AFU_STATUS_CSRS-1:0][63:0] inp2cr_port_afu_status;

    // Register block side
    modport master (
        output cr2out_port_control,
        output cr2out_port_error,
        output cr2out_port_error_clear,
        output cr2out_port_error_mask,
        input  inp2cr_port_control,
        input  inp2cr_port_status,
        input  inp2cr_port_error,
        input  inp2cr_port_malformed_req_0,
        input  inp2cr_port_malformed_req_1,
        input  inp2cr_port_debug0,
        input  inp2cr_port_stp_status,
        input  inp2cr_port_afu_status
    );

    modport slave (
        input  cr2out_port_control,
        input  cr2out_port_error,
        input  cr2out_port_error_clear,
        input  cr2out_port_error_mask,
        output inp2cr_port_control,
        output inp2cr_port_status,
        output inp2cr_port_error,
        output inp2cr_port_malformed_req_0,
        output inp2cr_port_malformed_req_1,
        output inp2cr_port_debug0,
        output inp2cr_port_stp_status,
        output inp2cr_port_afu_status
    );

    // Functional end of the port CSR block
    modport tb (
        input  cr2out_port_control,
        input  cr2out_port_error,
        input  cr2out_port_error_clear,
        input  cr2out_port_error_mask,
        output inp2cr_port_control,
        output inp2cr_port_status,
        output inp2cr_port_error,
        output inp2cr_port_malformed_req_0,
        output inp2cr_port_malformed_req_1,
        output inp2cr_port_debug0,
        output inp2cr_port_stp_status,
        output inp2cr_port_afu_status
    );

endinterface

// File: rtl/port_csr_ctrl_err_fsm.sv
// Port soft-reset sequencer: RUN/DRAIN/RESET/ACK FSM, drain timer,
// reset pulse counter and outstanding-request counter.
module port_soft_rst_fsm
    import ofs_fim_if_pkg::*;
#(
    parameter int OUTST_W       = 10,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int RST_CYC       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               req_issue,
    input  logic               req_done,
    output logic               drain,
    output logic               port_rst,
    output logic               ack,
    output logic               timeout,
    output logic               underflow,
    output logic [OUTST_W-1:0] outst
);

    localparam int TMR_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int RCNT_W = $clog2(RST_CYC + 1);

    port_ctrl_state_e state, state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [RCNT_W-1:0] rcnt;
    logic              enter_drain;
    logic              enter_rst;
    logic              to_timeout;

    always_comb begin
        state_nxt   = state;
        enter_drain = 1'b0;
        to_timeout  = 1'b0;
        unique case (state)
            RUN: begin
                if (req) begin
                    state_nxt   = DRAIN;
                    enter_drain = 1'b1;
                end
            end
            DRAIN: begin
                if (outst == '0) begin
                    state_nxt = RESET;
                end else if (tmr == TMR_W'(DRAIN_TIMEOUT - 1)) begin
                    state_nxt  = RESET;
                    to_timeout = 1'b1;
                end
            end
            RESET: begin
                if (rcnt == RCNT_W'(RST_CYC - 1)) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!req) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign enter_rst = (state == DRAIN) && (state_nxt == RESET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            tmr   <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= (state == DRAIN) ? tmr + TMR_W'(1) : '0;
            rcnt  <= (state == RESET) ? rcnt + RCNT_W'(1) : '0;
        end
    end

    // Timeout flag stays up until the next reset request is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (enter_drain) begin
            timeout <= 1'b0;
        end else if (to_timeout) begin
            timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst     <= '0;
            underflow <= 1'b0;
        end else if (enter_rst) begin
            outst     <= '0;
            underflow <= 1'b0;
        end else begin
            unique case ({req_issue, req_done})
                2'b10: begin
                    if (outst != '1) begin
                        outst <= outst + OUTST_W'(1);
                    end
                end
                2'b01: begin
                    if (outst == '0) begin
                        underflow <= 1'b1;
                    end else begin
                        outst <= outst - OUTST_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign drain    = (state != RUN);
    assign port_rst = (state == RESET);
    assign ack      = (state == ACK);

endmodule

// File: rtl/port_csr_ctrl_err.sv
// Port CSR functional end: soft-reset handshake, sticky errors,
// first-error/malformed capture, status. Option: PORT_ERR_TIMESTAMP_EN.
module port_csr_ctrl_err
    import ofs_fim_if_pkg::*;
#(
    parameter int NUM_ERR       = 16,
    parameter int MALF_ERR_IDX  = 3,
    parameter int OUTST_W       = 10,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int RST_CYC       = 16
) (
    input  logic                clk,
    input  logic                rst,
    port_csr_io_if.tb           csr_io,
    input  logic [NUM_ERR-1:0]  err_evt,
    input  logic [127:0]        malf_hdr,
    input  logic                req_issue,
    input  logic                req_done,
    input  logic [NUM_PORT_AFU_STATUS_CSRS-1:0][63:0] afu_status_in,
    output logic                drain,
    output logic                port_rst
);

    logic               ack;
    logic               timeout;
    logic               underflow;
    logic [OUTST_W-1:0] outst;
    logic               req;

    assign req = csr_io.cr2out_port_control[PORT_CTRL_RST_BIT];

    port_soft_rst_fsm #(
        .OUTST_W       (OUTST_W),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .RST_CYC       (RST_CYC)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_issue (req_issue),
        .req_done  (req_done),
        .drain     (drain),
        .port_rst  (port_rst),
        .ack       (ack),
        .timeout   (timeout),
        .underflow (underflow),
        .outst     (outst)
    );

    logic [63:0] ctrl_q;
    logic [NUM_PORT_AFU_STATUS_CSRS-1:0][63:0] afu_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            afu_q  <= '0;
        end else begin
            ctrl_q <= ctrl_readback(csr_io.cr2out_port_control, ack);
            afu_q  <= afu_status_in;
        end
    end

    logic [63:0] status;

    always_comb begin
        status = '0;
        status[0] = port_rst | drain;
        status[PORT_STS_TIMEOUT_BIT] = timeout;
        status[PORT_STS_UNDERFLOW_BIT] = underflow;
        status[PORT_STS_OUTST_LSB +: OUTST_W] = outst;
    end

    logic [NUM_ERR-1:0] err_set;
    logic [NUM_ERR-1:0] err_clr;
    logic [NUM_ERR-1:0] err_q;
    logic [NUM_ERR-1:0] err_nxt;
    logic [NUM_ERR-1:0] first_q;
    logic               first_cap;
    logic               first_clr;
    logic               malf_cap;
    logic [63:0]        malf0_q;
    logic [63:0]        malf1_q;

    assign err_set = err_evt & ~csr_io.cr2out_port_error_mask[NUM_ERR-1:0];
    assign err_clr = csr_io.cr2out_port_error_clear ?
                     csr_io.cr2out_port_error[NUM_ERR-1:0] : '0;
    // Set is applied after clear so a coincident event survives the W1C
    assign err_nxt = (err_q & ~err_clr) | err_set;

    assign first_cap = (err_q == '0) && (err_set != '0);
    assign first_clr = (err_nxt == '0);
    assign malf_cap  = err_set[MALF_ERR_IDX] & ~err_q[MALF_ERR_IDX];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q   <= '0;
            first_q <= '0;
        end else begin
            err_q <= err_nxt;
            if (first_cap) begin
                first_q <= err_set;
            end else if (first_clr) begin
                first_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            malf0_q <= '0;
            malf1_q <= '0;
        end else if (malf_cap) begin
            malf0_q <= malf_hdr[63:0];
            malf1_q <= malf_hdr[127:64];
        end else if (!err_nxt[MALF_ERR_IDX]) begin
            malf0_q <= '0;
            malf1_q <= '0;
        end
    end

    logic [63:0] debug0;
    logic [63:0] stp_status;

`ifdef PORT_ERR_TIMESTAMP_EN
    logic [47:0] ts;
    logic [47:0] first_ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts       <= '0;
            first_ts <= '0;
        end else begin
            ts <= ts + 48'd1;
            if (first_cap) begin
                first_ts <= ts;
            end else if (first_clr) begin
                first_ts <= '0;
            end
        end
    end

    assign debug0     = {first_ts, 16'(first_q)};
    assign stp_status = {16'h0, ts};
`else
    assign debug0     = 64'(first_q);
    assign stp_status = '0;
`endif

    assign csr_io.inp2cr_port_control         = ctrl_q;
    assign csr_io.inp2cr_port_status          = status;
    assign csr_io.inp2cr_port_error           = 64'(err_q);
    assign csr_io.inp2cr_port_malformed_req_0 = malf0_q;
    assign csr_io.inp2cr_port_malformed_req_1 = malf1_q;
    assign csr_io.inp2cr_port_debug0          = debug0;
    assign csr_io.inp2cr_port_stp_status      = stp_status;
    assign csr_io.inp2cr_port_afu_status      = afu_q;

    logic unused_ok;
    assign unused_ok = ^{csr_io.cr2out_port_error,
                         csr_io.cr2out_port_error_mask};

endmodule

// File: tb/tb_port_csr_ctrl_err.sv
// Directed bench for port_csr_ctrl_err: soft-reset handshake, drain
// timeout, error mask/clear, first-error/malformed capture, async reset.
module tb_port_csr_ctrl_err;
    import ofs_fim_if_pkg::*;

    logic         clk;
    logic         rst;
    logic [15:0]  err_evt;
    logic [127:0] malf_hdr;
    logic         req_issue;
    logic         req_done;
    logic [NUM_PORT_AFU_STATUS_CSRS-1:0][63:0] afu_status_in;
    logic         drain;
    logic         port_rst;

    int errors = 0;
    int checks = 0;

    port_csr_io_if csr_io ();

    port_csr_ctrl_err dut (
        .clk           (clk),
        .rst           (rst),
        .csr_io        (csr_io),
        .err_evt       (err_evt),
        .malf_hdr      (malf_hdr),
        .req_issue     (req_issue),
        .req_done      (req_done),
        .afu_status_in (afu_status_in),
        .drain         (drain),
        .port_rst      (port_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (drain !== 1'b0 || port_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs drain=%b port_rst=%b want 0 0", drain, port_rst);
        end
        checks++;
        if (csr_io.inp2cr_port_control !== 64'h0 || csr_io.inp2cr_port_status !== 64'h0) begin
            errors++;
            $display("FAIL reset_ctrl_sts ctrl=%h sts=%h want 0", csr_io.inp2cr_port_control, csr_io.inp2cr_port_status);
        end
        checks++;
        if (csr_io.inp2cr_port_error !== 64'h0 || csr_io.inp2cr_port_debug0 !== 64'h0 ||
            csr_io.inp2cr_port_stp_status !== 64'h0 || csr_io.inp2cr_port_afu_status !== '0 ||
            csr_io.inp2cr_port_malformed_req_0 !== 64'h0 || csr_io.inp2cr_port_malformed_req_1 !== 64'h0) begin
            errors++;
            $display("FAIL reset_err_regs err=%h dbg=%h stp=%h want 0", csr_io.inp2cr_port_error, csr_io.inp2cr_port_debug0, csr_io.inp2cr_port_stp_status);
        end
    endtask

    task automatic test_ctrl_afu();
        csr_io.cr2out_port_control = 64'hDEAD_BEEF_0000_00F2;
        afu_status_in[0] = 64'h1111_2222_3333_4444;
        afu_status_in[1] = 64'h5555_6666_7777_8888;
        tick();
        checks++;
        if (csr_io.inp2cr_port_control !== 64'hDEAD_BEEF_0000_00E2) begin
            errors++;
            $display("FAIL ctrl_readback got=%h want=%h", csr_io.inp2cr_port_control, 64'hDEAD_BEEF_0000_00E2);
        end
        checks++;
        if (csr_io.inp2cr_port_afu_status[0] !== 64'h1111_2222_3333_4444 ||
            csr_io.inp2cr_port_afu_status[1] !== 64'h5555_6666_7777_8888) begin
            errors++;
            $display("FAIL afu_status got=%h %h", csr_io.inp2cr_port_afu_status[0], csr_io.inp2cr_port_afu_status[1]);
        end
        checks++;
        if (drain !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_no_req drain=%b want 0", drain);
        end
        csr_io.cr2out_port_control = 64'h0;
        tick();
    endtask

    task automatic test_counter_edges();
        req_done = 1'b1;
        tick();
        req_done = 1'b0;
        checks++;
        if (csr_io.inp2cr_port_status[17:8] !== 10'd0 || csr_io.inp2cr_port_status[2] !== 1'b1) begin
            errors++;
            $display("FAIL underflow sts=%h want outst=0 bit2=1", csr_io.inp2cr_port_status);
        end
        req_issue = 1'b1;
        tick();
        tick();
        req_issue = 1'b0;
        checks++;
        if (csr_io.inp2cr_port_status[17:8] !== 10'd2) begin
            errors++;
            $display("FAIL issue_count got=%0d want=2", csr_io.inp2cr_port_status[17:8]);
        end
        req_issue = 1'b1;
        req_done  = 1'b1;
        tick();
        req_issue = 1'b0;
        req_done  = 1'b0;
        checks++;
        if (csr_io.inp2cr_port_status[17:8] !== 10'd2) begin
            errors++;
            $display("FAIL issue_done_same got=%0d want=2", csr_io.inp2cr_port_status[17:8]);
        end
    endtask

    task automatic test_drain_timeout();
        int cnt;
        csr_io.cr2out_port_control = 64'h1;
        tick();
        cnt = 0;
        while (drain === 1'b1 && port_rst === 1'b0 && cnt < 5000) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 4096) begin
            errors++;
            $display("FAIL drain_cycles got=%0d want=4096", cnt);
        end
        checks++;
        if (port_rst !== 1'b1 || csr_io.inp2cr_port_status[1] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_reset port_rst=%b sts=%h want 1, bit1=1", port_rst, csr_io.inp2cr_port_status);
        end
        checks++;
        if (csr_io.inp2cr_port_status[17:8] !== 10'd0 || csr_io.inp2cr_port_status[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_entry_clr sts=%h want outst=0 bit2=0", csr_io.inp2cr_port_status);
        end
        csr_io.cr2out_port_control = 64'h0;
        cnt = 0;
        while (drain === 1'b1 && cnt < 64) begin
            cnt++;
            tick();
        end
        checks++;
        if (drain !== 1'b0 || csr_io.inp2cr_port_status[1] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky drain=%b sts=%h want 0, bit1=1", drain, csr_io.inp2cr_port_status);
        end
    endtask

    task automatic test_soft_reset();
        int cnt;
        bit bad;
        req_issue = 1'b1;
        repeat (3) tick();
        req_issue = 1'b0;
        csr_io.cr2out_port_control = 64'h1;
        tick();
        checks++;
        if (drain !== 1'b1 || csr_io.inp2cr_port_status[1:0] !== 2'b01 ||
            csr_io.inp2cr_port_status[17:8] !== 10'd3) begin
            errors++;
            $display("FAIL drain_entry drain=%b sts=%h want 1, bits1:0=01 outst=3", drain, csr_io.inp2cr_port_status);
        end
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (10) begin
                tick();
                if (drain !== 1'b1 || port_rst !== 1'b0) bad = 1'b1;
            end
            req_done = 1'b1;
            tick();
            req_done = 1'b0;
        end
        checks++;
        if (bad || port_rst !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold bad=%b port_rst=%b want 0 0", bad, port_rst);
        end
        tick();
        checks++;
        if (port_rst !== 1'b1) begin
            errors++;
            $display("FAIL rst_rise port_rst=%b want 1", port_rst);
        end
        cnt = 0;
        while (port_rst === 1'b1 && cnt < 64) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 16) begin
            errors++;
            $display("FAIL rst_len got=%0d want=16", cnt);
        end
        tick();
        checks++;
        if (csr_io.inp2cr_port_control !== 64'h11 || drain !== 1'b1) begin
            errors++;
            $display("FAIL ack_set ctrl=%h drain=%b want 11 1", csr_io.inp2cr_port_control, drain);
        end
        csr_io.cr2out_port_control = 64'h0;
        tick();
        checks++;
        if (drain !== 1'b0 || csr_io.inp2cr_port_status[0] !== 1'b0) begin
            errors++;
            $display("FAIL ack_exit drain=%b sts=%h want 0", drain, csr_io.inp2cr_port_status);
        end
        tick();
        checks++;
        if (csr_io.inp2cr_port_control !== 64'h0) begin
            errors++;
            $display("FAIL ack_clr ctrl=%h want 0", csr_io.inp2cr_port_control);
        end
    endtask

    task automatic test_mask_clear();
        csr_io.cr2out_port_error_mask = 64'h4;
        err_evt = 16'h0006;
        tick();
        err_evt = 16'h0;
        checks++;
        if (csr_io.inp2cr_port_error !== 64'h2) begin
            errors++;
            $display("FAIL err_mask got=%h want=2", csr_io.inp2cr_port_error);
        end
        err_evt = 16'h0002;
        csr_io.cr2out_port_error = 64'h2;
        csr_io.cr2out_port_error_clear = 1'b1;
        tick();
        err_evt = 16'h0;
        csr_io.cr2out_port_error_clear = 1'b0;
        checks++;
        if (csr_io.inp2cr_port_error !== 64'h2) begin
            errors++;
            $display("FAIL set_wins got=%h want=2", csr_io.inp2cr_port_error);
        end
        csr_io.cr2out_port_error_clear = 1'b1;
        tick();
        csr_io.cr2out_port_error_clear = 1'b0;
        checks++;
        if (csr_io.inp2cr_port_error !== 64'h0 || csr_io.inp2cr_port_debug0[15:0] !== 16'h0) begin
            errors++;
            $display("FAIL err_clear err=%h dbg=%h want 0", csr_io.inp2cr_port_error, csr_io.inp2cr_port_debug0);
        end
        csr_io.cr2out_port_error_mask = 64'h0;
    endtask

    task automatic test_first_malf();
        logic [127:0] hdr;
        hdr = 128'hA5A5_0123_4567_89AB_CDEF_FEDC_BA98_765A;
        err_evt  = 16'h0008;
        malf_hdr = hdr;
        tick();
        err_evt  = 16'h0;
        checks++;
        if (csr_io.inp2cr_port_malformed_req_0 !== 64'hCDEF_FEDC_BA98_765A ||
            csr_io.inp2cr_port_malformed_req_1 !== 64'hA5A5_0123_4567_89AB) begin
            errors++;
            $display("FAIL malf_cap got=%h %h", csr_io.inp2cr_port_malformed_req_1, csr_io.inp2cr_port_malformed_req_0);
        end
        checks++;
        if (csr_io.inp2cr_port_debug0[15:0] !== 16'h0008) begin
            errors++;
            $display("FAIL first_cap got=%h want=0008", csr_io.inp2cr_port_debug0[15:0]);
        end
        err_evt  = 16'h0018;
        malf_hdr = 128'h1;
        tick();
        err_evt  = 16'h0;
        checks++;
        if (csr_io.inp2cr_port_malformed_req_0 !== 64'hCDEF_FEDC_BA98_765A ||
            csr_io.inp2cr_port_malformed_req_1 !== 64'hA5A5_0123_4567_89AB ||
            csr_io.inp2cr_port_debug0[15:0] !== 16'h0008 ||
            csr_io.inp2cr_port_error !== 64'h18) begin
            errors++;
            $display("FAIL capture_frozen m0=%h dbg=%h err=%h", csr_io.inp2cr_port_malformed_req_0, csr_io.inp2cr_port_debug0, csr_io.inp2cr_port_error);
        end
        csr_io.cr2out_port_error = 64'h18;
        csr_io.cr2out_port_error_clear = 1'b1;
        tick();
        csr_io.cr2out_port_error_clear = 1'b0;
        checks++;
        if (csr_io.inp2cr_port_malformed_req_0 !== 64'h0 || csr_io.inp2cr_port_malformed_req_1 !== 64'h0 ||
            csr_io.inp2cr_port_debug0 !== 64'h0 || csr_io.inp2cr_port_error !== 64'h0) begin
            errors++;
            $display("FAIL capture_clear m0=%h m1=%h dbg=%h err=%h", csr_io.inp2cr_port_malformed_req_0, csr_io.inp2cr_port_malformed_req_1, csr_io.inp2cr_port_debug0, csr_io.inp2cr_port_error);
        end
    endtask

    task automatic test_mid_reset();
        err_evt = 16'h0001;
        csr_io.cr2out_port_control = 64'h1;
        tick();
        err_evt = 16'h0;
        tick();
        tick();
        checks++;
        if (port_rst !== 1'b1 || csr_io.inp2cr_port_error !== 64'h1) begin
            errors++;
            $display("FAIL pre_rst port_rst=%b err=%h want 1 1", port_rst, csr_io.inp2cr_port_error);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (port_rst !== 1'b0 || drain !== 1'b0 || csr_io.inp2cr_port_control !== 64'h0 ||
            csr_io.inp2cr_port_status !== 64'h0 || csr_io.inp2cr_port_error !== 64'h0 ||
            csr_io.inp2cr_port_afu_status !== '0 || csr_io.inp2cr_port_debug0 !== 64'h0) begin
            errors++;
            $display("FAIL async_rst port_rst=%b drain=%b ctrl=%h sts=%h err=%h", port_rst, drain, csr_io.inp2cr_port_control, csr_io.inp2cr_port_status, csr_io.inp2cr_port_error);
        end
        csr_io.cr2out_port_control = 64'h0;
        #2;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (drain !== 1'b0 || port_rst !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_run drain=%b port_rst=%b want 0 0", drain, port_rst);
        end
        csr_io.cr2out_port_control = 64'h1;
        tick();
        checks++;
        if (drain !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_req drain=%b want 1", drain);
        end
        csr_io.cr2out_port_control = 64'h0;
    endtask

    initial begin
        rst = 1'b1;
        err_evt = '0;
        malf_hdr = '0;
        req_issue = 1'b0;
        req_done = 1'b0;
        afu_status_in = '0;
        csr_io.cr2out_port_control = '0;
        csr_io.cr2out_port_error = '0;
        csr_io.cr2out_port_error_clear = 1'b0;
        csr_io.cr2out_port_error_mask = '0;
        #22;
        test_reset();
        rst = 1'b0;
        tick();
        test_ctrl_afu();
        test_counter_edges();
        test_drain_timeout();
        test_soft_reset();
        test_mask_clear();
        test_first_malf();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
